dmem_pipe: RTL

- Next-generation parametrised data memory for the core's load/store path.
- Adds the following over a plain word array:
  - a valid/ready request interface
  - configurable read latency
  - sub-word load/store with sign/zero extension
  - alignment and range faults
  - a post-reset clear sequencer
- Sits between the LSU and the memory array.
- Optional MMIO decode provides signature output and halt.

---
 rtl/dmem_pipe_if.sv | 28 ++
 rtl/dmem_pipe.sv | 136 +++++++++++++
 2 files changed

// File: rtl/dmem_pipe_if.sv
// dmem_pipe_if: LSU request/response bus plus the MMIO signature and halt outputs.
interface dmem_pipe_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  sig_valid;
  logic [DATA_WIDTH-1:0] sig_data;
  logic                  halt;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, sig_valid, sig_data, halt
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, sig_valid, sig_data, halt
  );
endinterface

// File: rtl/dmem_pipe.sv
// dmem_pipe: pipelined data memory with sub-word access, fault checks and post-reset clear.
// Define DMEM_MMIO_EN to decode the signature (SIG_ADDR) and halt (HALT_ADDR) MMIO stores.
module dmem_pipe #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DMEM_SZ_IN_KB = 4,
  parameter int unsigned READ_LATENCY  = 1,
  parameter logic [31:0] SIG_ADDR      = 32'h8E00_0000,
  parameter logic [31:0] HALT_ADDR     = 32'h8F00_0000
) (
  input logic        clk,
  input logic        arst,
  dmem_pipe_if.slave bus
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = DMEM_SZ_IN_KB * 1024 / BYTES;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_HALT} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      clr_cnt_q, clr_cnt_d;
  logic                  req_ready_q, halt_q, sig_valid_q;
  logic [DATA_WIDTH-1:0] sig_data_q;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [READ_LATENCY-1:0] pv_q, pe_q;
  logic [DATA_WIDTH-1:0]   pd_q [READ_LATENCY];

  logic                  acc_c, err_c, mmio_c, wr_c, sig_st_c, halt_st_c;
  logic [OFF_W-1:0]      off_c;
  logic [31:0]           idx_c;
  logic [BYTES-1:0]      be_c;
  logic [DATA_WIDTH-1:0] wsh_c, rword_c, lane_c, ld_c, rdata_c;

  // Request decode: fault detection, byte lanes, and the extended load value.
  always_comb begin : decode
    acc_c = bus.req_valid && req_ready_q;
    off_c = bus.req_addr[OFF_W-1:0];
    idx_c = bus.req_addr >> OFF_W;
`ifdef DMEM_MMIO_EN
    mmio_c = (bus.req_addr == SIG_ADDR) || (bus.req_addr == HALT_ADDR);
`else
    mmio_c = 1'b0;
`endif
    err_c = ((32'(off_c) & ((32'd1 << bus.req_size) - 32'd1)) != 32'd0)
         || ((bus.req_size == 2'd3) && (DATA_WIDTH == 32))
         || (!mmio_c && (idx_c >= 32'(DEPTH)));
    wr_c      = acc_c && bus.req_we && !err_c && !mmio_c;
    sig_st_c  = acc_c && bus.req_we && !err_c && mmio_c
             && (bus.req_size == 2'd2) && (bus.req_addr == SIG_ADDR);
    halt_st_c = acc_c && bus.req_we && !err_c && mmio_c && (bus.req_addr == HALT_ADDR);
    be_c    = BYTES'(((32'd1 << (32'd1 << bus.req_size)) - 32'd1) << off_c);
    wsh_c   = bus.req_wdata << {off_c, 3'b000};
    rword_c = mem_q[idx_c[IDX_W-1:0]];
    lane_c  = rword_c >> {off_c, 3'b000};
    case (bus.req_size)
      2'd0:    ld_c = bus.req_unsigned ? DATA_WIDTH'(lane_c[7:0])
                                       : DATA_WIDTH'($signed(lane_c[7:0]));
      2'd1:    ld_c = bus.req_unsigned ? DATA_WIDTH'(lane_c[15:0])
                                       : DATA_WIDTH'($signed(lane_c[15:0]));
      2'd2:    ld_c = bus.req_unsigned ? DATA_WIDTH'(lane_c[31:0])
                                       : DATA_WIDTH'($signed(lane_c[31:0]));
      default: ld_c = lane_c;
    endcase
    rdata_c = (bus.req_we || err_c || mmio_c) ? '0 : ld_c;
  end

  // CLEAR walks every word once, then RUN until a halt store.
  always_comb begin : fsm
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + IDX_W'(1);
        if (clr_cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN:  if (halt_st_c) state_d = ST_HALT;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin : ctrl_regs
    if (arst) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      req_ready_q <= 1'b0;
      halt_q      <= 1'b0;
      sig_valid_q <= 1'b0;
      sig_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      req_ready_q <= (state_d == ST_RUN);
      halt_q      <= (state_d == ST_HALT);
      sig_valid_q <= sig_st_c;
      if (sig_st_c) sig_data_q <= bus.req_wdata;
    end
  end

  // Fixed-latency response shift register; reset drops everything in flight.
  always_ff @(posedge clk or posedge arst) begin : rsp_pipe
    if (arst) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pd_q[i] <= '0;
    end else begin
      pv_q[0] <= acc_c;
      pe_q[0] <= acc_c && err_c;
      pd_q[0] <= acc_c ? rdata_c : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin : mem_write
    if (state_q == ST_CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_c) begin
      for (int b = 0; b < BYTES; b++)
        if (be_c[b]) mem_q[idx_c[IDX_W-1:0]][8*b +: 8] <= wsh_c[8*b +: 8];
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = pv_q[READ_LATENCY-1];
  assign bus.rsp_err   = pe_q[READ_LATENCY-1];
  assign bus.rsp_rdata = pd_q[READ_LATENCY-1];
  assign bus.sig_valid = sig_valid_q;
  assign bus.sig_data  = sig_data_q;
  assign bus.halt      = halt_q;

endmodule
